// File: rtl/ahb_switch_in.sv
// AHB-Lite zero-wait-state slave returning synchronised, debounced switch and button inputs,
// with a W1C rising-edge status register and a level interrupt on enabled edges.
module ahb_switch_in #(
  parameter int NSW       = 16,
  parameter int NBTN      = 5,
  parameter int DB_CYCLES = 100000
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic            HREADY,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [31:0]     HADDR,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  output logic            HREADYOUT,
  output logic            HRESP,
  input  logic [NSW-1:0]  SW_IN,
  input  logic [NBTN-1:0] BTN_IN,
  output logic            IRQ
);

  localparam int NI = NSW + NBTN;
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  localparam logic [1:0] A_SW   = 2'd0;
  localparam logic [1:0] A_BTN  = 2'd1;
  localparam logic [1:0] A_EDGE = 2'd2;
  localparam logic [1:0] A_IEN  = 2'd3;

  // Internal vectors hold switches in [NSW-1:0] and buttons above; the bus view puts buttons at bit 16.
  function automatic logic [31:0] f_to_bus(input logic [NI-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[NSW-1:0]    = v[NSW-1:0];
    r[16 +: NBTN] = v[NI-1:NSW];
    return r;
  endfunction

  function automatic logic [NI-1:0] f_from_bus(input logic [31:0] d);
    return {d[16 +: NBTN], d[NSW-1:0]};
  endfunction

  logic [NI-1:0] r_sync1;
  logic [NI-1:0] r_sync2;
  logic [NI-1:0] r_stable;
  logic [CW-1:0] r_cnt [NI];
  logic [NI-1:0] r_edge;
  logic [NI-1:0] r_irq_en;
  logic          r_dp_valid;
  logic          r_dp_write;
  logic [1:0]    r_dp_addr;
  logic [31:0]   r_hrdata;
  logic          r_irq;

  logic          w_acc;
  logic          w_wr_edge;
  logic          w_wr_ien;
  logic [NI-1:0] w_rise;
  logic [NI-1:0] w_clr;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  assign w_unused = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  // Two-flop synchroniser on every raw input pin.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {BTN_IN, SW_IN};
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: stable follows sync only after it differed for DB_CYCLES consecutive cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_stable <= '0;
      for (int i = 0; i < NI; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i]    <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge qualifies in the same cycle the stable bit is about to flip 0->1.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < NI; i++) begin
      w_rise[i] = r_sync2[i] & ~r_stable[i] & (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_acc     = HSEL & HREADY & HTRANS[1];
  assign w_wr_edge = r_dp_valid & r_dp_write & (r_dp_addr == A_EDGE);
  assign w_wr_ien  = r_dp_valid & r_dp_write & (r_dp_addr == A_IEN);
  assign w_clr     = w_wr_edge ? f_from_bus(HWDATA) : '0;

  // Address-phase capture for the following data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else begin
      r_dp_valid <= w_acc;
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[3:2];
    end
  end

  // Edge status (set beats clear) and interrupt enable registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_edge   <= '0;
      r_irq_en <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_rise;
      if (w_wr_ien) begin
        r_irq_en <= f_from_bus(HWDATA);
      end else begin
        r_irq_en <= r_irq_en;
      end
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    w_rd_val = 32'd0;
    case (HADDR[3:2])
      A_SW:    w_rd_val = 32'(r_stable[NSW-1:0]);
      A_BTN:   w_rd_val = 32'(r_stable[NI-1:NSW]);
      A_EDGE:  w_rd_val = f_to_bus(r_edge);
      A_IEN:   w_rd_val = f_to_bus(r_irq_en);
      default: w_rd_val = 32'd0;
    endcase
  end

  // Read data is captured at address acceptance, so a preceding write is never forwarded.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_hrdata <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      r_hrdata <= (w_acc & ~HWRITE) ? w_rd_val : 32'd0;
      r_irq    <= |(r_edge & r_irq_en);
    end
  end

  assign HRDATA    = r_hrdata;
  assign IRQ       = r_irq;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_switch_in.sv
// Directed self-checking bench for ahb_switch_in with a short debounce window.
module tb_ahb_switch_in;

  localparam int NSW  = 16;
  localparam int NBTN = 5;
  localparam int DB   = 8;

  logic            hclk;
  logic            hreset;
  logic            hsel;
  logic            hready;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [31:0]     haddr;
  logic [31:0]     hwdata;
  logic [31:0]     hrdata;
  logic            hreadyout;
  logic            hresp;
  logic [NSW-1:0]  sw_in;
  logic [NBTN-1:0] btn_in;
  logic            irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] rd;

  ahb_switch_in #(.NSW(NSW), .NBTN(NBTN), .DB_CYCLES(DB)) dut (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .SW_IN(sw_in), .BTN_IN(btn_in), .IRQ(irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'd0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    tick();
    bus_idle();
    hwdata = d;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    tick();
    d = hrdata;
    bus_idle();
  endtask

  initial begin
    hreset = 1'b1; hready = 1'b1; hwdata = 32'd0;
    sw_in = '0; btn_in = '0;
    bus_idle();

    // Reset
    repeat (3) tick();
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    hreset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ahb_read(32'(a * 4), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'd0);
    end

    // Switch debounce latency: stable flips at the 10th edge after the pin change
    sw_in = 16'hA5A5;
    repeat (9) tick();
    ahb_read(32'h0, rd);
    check("sw_early", rd, 32'd0);
    ahb_read(32'h0, rd);
    check("sw_state", rd, 32'h0000A5A5);
    ahb_read(32'h8, rd);
    check("sw_edges", rd, 32'h0000A5A5);
    check("sw_no_irq", {31'd0, irq}, 32'd0);

    // Writes to a read-only offset are ignored
    ahb_write(32'h0, 32'h00000000);
    ahb_read(32'h0, rd);
    check("ro_write", rd, 32'h0000A5A5);

    // IDLE transfer with HSEL does not produce read data
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0;
    tick();
    check("idle_rd", hrdata, 32'd0);
    bus_idle();

    // Short button glitch is rejected
    btn_in[0] = 1'b1;
    repeat (5) tick();
    btn_in[0] = 1'b0;
    repeat (20) tick();
    ahb_read(32'h4, rd);
    check("glitch_btn", rd, 32'd0);
    ahb_read(32'h8, rd);
    check("glitch_edge", rd, 32'h0000A5A5);

    // Enabled button edge raises IRQ; W1C behaviour
    ahb_write(32'h8, 32'hFFFFFFFF);
    ahb_read(32'h8, rd);
    check("w1c_all", rd, 32'd0);
    ahb_write(32'hC, 32'h00010000);
    ahb_read(32'hC, rd);
    check("ien_rd", rd, 32'h00010000);
    btn_in[0] = 1'b1;
    repeat (10) tick();
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    ahb_read(32'h8, rd);
    check("btn_edge", rd, 32'h00010000);
    ahb_read(32'h4, rd);
    check("btn_state", rd, 32'h00000001);
    ahb_write(32'h8, 32'h00000000);
    ahb_read(32'h8, rd);
    check("w1c_zero", rd, 32'h00010000);
    check("irq_kept", {31'd0, irq}, 32'd1);
    ahb_write(32'h8, 32'h00010000);
    tick();
    check("irq_clr", {31'd0, irq}, 32'd0);
    ahb_read(32'h8, rd);
    check("w1c_bit16", rd, 32'd0);

    // Falling edge ignored, then W1C coinciding with a new rising edge
    btn_in[0] = 1'b0;
    repeat (12) tick();
    ahb_read(32'h4, rd);
    check("btn_fall", rd, 32'd0);
    ahb_read(32'h8, rd);
    check("fall_no_edge", rd, 32'd0);
    btn_in[0] = 1'b1;
    repeat (8) tick();
    ahb_write(32'h8, 32'h00010000);
    ahb_read(32'h8, rd);
    check("set_wins", rd, 32'h00010000);
    check("set_wins_irq", {31'd0, irq}, 32'd1);

    // Back-to-back write then read of IRQ_EN: read sees the pre-write value
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'hC;
    tick();
    check("b2b_ready", {31'd0, hreadyout}, 32'd1);
    check("b2b_resp", {31'd0, hresp}, 32'd0);
    hwdata = 32'hFFFF001F; hwrite = 1'b0; haddr = 32'hC;
    tick();
    check("b2b_old", hrdata, 32'h00010000);
    check("b2b_ready2", {31'd0, hreadyout}, 32'd1);
    check("b2b_resp2", {31'd0, hresp}, 32'd0);
    bus_idle();
    ahb_read(32'hC, rd);
    check("b2b_new", rd, 32'h001F001F);

    // BUSY transfer does not write
    hsel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'hC;
    tick();
    bus_idle();
    hwdata = 32'h00000000;
    tick();
    ahb_read(32'hC, rd);
    check("busy_nowr", rd, 32'h001F001F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
